// File: rtl/bf16_pkg.sv
// Shared bfloat16 definitions for the CNN datapath multiplier (and, later, the adder).
package bf16_pkg;

  localparam int BF16_EXP_W       = 8;
  localparam int BF16_FRAC_W      = 7;
  localparam int BF16_MUL_LATENCY = 4;

  localparam logic signed [9:0] BF16_BIAS = 10'sd127;
  localparam logic signed [9:0] BF16_EMIN = -10'sd126;
  localparam logic [15:0]       BF16_QNAN = 16'hFFFF;
  localparam logic [15:0]       BF16_ZERO = 16'h0000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    MULT  = 3'd2,
    NORM  = 3'd3,
    DONE  = 3'd4
  } state_t;

  // A zero exponent field is a denormal and shares the minimum exponent.
  function automatic logic signed [9:0] bf16_unbias(input logic [BF16_EXP_W-1:0] field);
    logic signed [9:0] r;
    if (field == 8'h00) r = BF16_EMIN;
    else r = $signed({2'b00, field}) - BF16_BIAS;
    return r;
  endfunction

endpackage

// File: rtl/bf16_lzc.sv
// 8-bit leading-zero counter; an all-zero input reports 8.
module bf16_lzc (
  input  logic [7:0] value,
  output logic [3:0] count
);

  // Priority encode from the MSB down
  always_comb begin
    casez (value)
      8'b1???????: count = 4'd0;
      8'b01??????: count = 4'd1;
      8'b001?????: count = 4'd2;
      8'b0001????: count = 4'd3;
      8'b00001???: count = 4'd4;
      8'b000001??: count = 4'd5;
      8'b0000001?: count = 4'd6;
      8'b00000001: count = 4'd7;
      default:     count = 4'd8;
    endcase
  end

endmodule

// File: rtl/bfloat16_mul.sv
// Multi-cycle bfloat16 multiplier: IDLE->CHECK->MULT->NORM(two cycles)->DONE, latency 4.
// Truncates by default; define BF16_MUL_RNE_EN for round-to-nearest-even in NORM.
module bfloat16_mul
  import bf16_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out
);

  state_t                 state_r;
  logic [15:0]            a_r, b_r, p_r, out_r;
  logic                   sign_r, nan_r, zero_r, norm_phase_r;
  logic                   in_ready_r, out_valid_r;
  logic signed [9:0]      ea_r, eb_r, e_r;
  logic [BF16_FRAC_W:0]   ma_r, mb_r;
`ifdef BF16_MUL_RNE_EN
  logic                   sticky_r;
`endif

  logic [3:0]             lz_s, shift_s;
  logic [9:0]             headroom_s;
  logic signed [9:0]      biased_s;
  logic                   round_s;
  logic [14:0]            mag_s;
  logic [15:0]            result_s;

  bf16_lzc u_lzc (
    .value (p_r[14:7]),
    .count (lz_s)
  );

  // Normalizing shift, clamped so the exponent never drops below the minimum
  always_comb begin
    headroom_s = 10'(e_r - BF16_EMIN);
    if (e_r < BF16_EMIN) shift_s = 4'd0;
    else if (headroom_s < {6'd0, lz_s}) shift_s = headroom_s[3:0];
    else shift_s = lz_s;
  end

  // Pack the normalized product; p_r[14]=0 here means a denormal result
  always_comb begin
    biased_s = e_r + BF16_BIAS;
`ifdef BF16_MUL_RNE_EN
    round_s = p_r[6] & ((|p_r[5:0]) | sticky_r | p_r[7]);
`else
    round_s = 1'b0;
`endif
    mag_s = {(p_r[14] ? biased_s[7:0] : 8'h00), p_r[13:7]} + {14'd0, round_s};
    if (nan_r) result_s = BF16_QNAN;
    else if (zero_r) result_s = BF16_ZERO;
    else if (biased_s > 10'sd254) result_s = BF16_QNAN;
    else if (biased_s < 10'sd1) result_s = BF16_ZERO;
    else if (mag_s[14:7] == 8'hFF) result_s = BF16_QNAN;
    else result_s = {sign_r, mag_s};
  end

  // Control FSM with the datapath registers it sequences
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      a_r          <= 16'h0000;
      b_r          <= 16'h0000;
      p_r          <= 16'h0000;
      out_r        <= 16'h0000;
      sign_r       <= 1'b0;
      nan_r        <= 1'b0;
      zero_r       <= 1'b0;
      norm_phase_r <= 1'b0;
      in_ready_r   <= 1'b1;
      out_valid_r  <= 1'b0;
      ea_r         <= 10'sd0;
      eb_r         <= 10'sd0;
      e_r          <= 10'sd0;
      ma_r         <= 8'h00;
      mb_r         <= 8'h00;
`ifdef BF16_MUL_RNE_EN
      sticky_r     <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready_r) begin
            a_r        <= a;
            b_r        <= b;
            in_ready_r <= 1'b0;
            state_r    <= CHECK;
          end
        end
        CHECK: begin
          sign_r  <= a_r[15] ^ b_r[15];
          nan_r   <= (a_r[14:7] == 8'hFF) || (b_r[14:7] == 8'hFF);
          zero_r  <= (a_r[14:0] == 15'd0) || (b_r[14:0] == 15'd0);
          ea_r    <= bf16_unbias(a_r[14:7]);
          eb_r    <= bf16_unbias(b_r[14:7]);
          ma_r    <= {(a_r[14:7] != 8'h00), a_r[6:0]};
          mb_r    <= {(b_r[14:7] != 8'h00), b_r[6:0]};
          state_r <= MULT;
        end
        MULT: begin
          p_r          <= 16'(ma_r) * 16'(mb_r);
          e_r          <= ea_r + eb_r;
          norm_phase_r <= 1'b0;
          state_r      <= NORM;
        end
        NORM: begin
          if (!norm_phase_r) begin
            norm_phase_r <= 1'b1;
            // Align so the mantissa always sits in p_r[13:7]
            if (p_r[15]) begin
              p_r <= {1'b0, p_r[15:1]};
              e_r <= e_r + 10'sd1;
`ifdef BF16_MUL_RNE_EN
              sticky_r <= p_r[0];
`endif
            end else begin
              p_r <= p_r << shift_s;
              e_r <= e_r - $signed({6'd0, shift_s});
`ifdef BF16_MUL_RNE_EN
              sticky_r <= 1'b0;
`endif
            end
          end else begin
            out_r        <= result_s;
            out_valid_r  <= 1'b1;
            norm_phase_r <= 1'b0;
            state_r      <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          out_valid_r  <= 1'b0;
          in_ready_r   <= 1'b1;
          norm_phase_r <= 1'b0;
          state_r      <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out       = out_r;

endmodule

// File: tb/tb_bfloat16_mul.sv
// Scoreboard bench for bfloat16_mul: directed plan vectors plus random operands vs a value-level model.
module tb_bfloat16_mul;

`ifdef BF16_MUL_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] a = 16'h0000;
  logic [15:0] b = 16'h0000;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out;

  typedef struct packed {
    logic [15:0] exp;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   prev_valid = 1'b0;

  bfloat16_mul dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Value-level reference: product = P * 2^(E-14), then encode per the flush/overflow rules.
  function automatic logic [15:0] model(input logic [15:0] x, input logic [15:0] y);
    int mx, my, ex, ey, p, e, k, n, sh, q, rem, half, enc;
    if (x[14:7] == 8'hFF || y[14:7] == 8'hFF) return 16'hFFFF;
    if (x[14:0] == 15'd0 || y[14:0] == 15'd0) return 16'h0000;
    mx = (x[14:7] == 8'd0) ? int'(x[6:0]) : 128 + int'(x[6:0]);
    my = (y[14:7] == 8'd0) ? int'(y[6:0]) : 128 + int'(y[6:0]);
    ex = (x[14:7] == 8'd0) ? -126 : int'(x[14:7]) - 127;
    ey = (y[14:7] == 8'd0) ? -126 : int'(y[14:7]) - 127;
    p = mx * my;
    e = ex + ey;
    k = 15;
    while (k > 0 && ((p >> k) & 1) == 0) k--;
    n = e + k - 14;
    if ((k >= 14) ? (n < -126) : (e < -126)) return 16'h0000;
    sh = (n >= -126) ? (k - 7) : (-119 - e);
    if (sh > 0) begin
      q = p >> sh;
      rem = p & ((1 << sh) - 1);
      half = 1 << (sh - 1);
      if (RNE && (rem > half || (rem == half && (q & 1) == 1))) q++;
    end else begin
      q = p << (-sh);
    end
    enc = (n >= -126) ? (n + 126) * 128 + q : q;
    if (enc >= 32640) return 16'hFFFF;
    return {x[15] ^ y[15], 15'(enc)};
  endfunction

  function automatic logic [15:0] rnd_op();
    logic [7:0] e;
    logic [6:0] f;
    int k;
    k = $urandom_range(0, 9);
    case (k)
      0:       e = 8'h00;
      1:       e = 8'hFF;
      2, 3, 4: e = 8'($urandom_range(100, 155));
      5:       e = 8'($urandom_range(1, 12));
      6:       e = 8'($urandom_range(240, 254));
      default: e = 8'($urandom);
    endcase
    f = (k == 7) ? 7'd0 : 7'($urandom);
    return {1'($urandom), e, f};
  endfunction

  // Monitor: latency on each out_valid rise, value on each transfer
  always @(negedge clk) begin
    if (reset) begin
      if (out_valid && !prev_valid) begin
        if (sb.size() == 0) check("spurious_out_valid", out_valid, 1'b0);
        else check("latency", cyc - sb[0].acc, 4);
      end
      if (out_valid && out_ready && sb.size() != 0) begin
        check("product", out, sb[0].exp);
        sb.pop_front();
      end
    end
    prev_valid = out_valid;
  end

  task automatic issue(input logic [15:0] x, input logic [15:0] y, input logic [15:0] e);
    int n = 0;
    @(negedge clk);
    a = x;
    b = y;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("accept", in_ready, 1'b1);
    if (in_ready) sb.push_back('{exp: e, acc: cyc + 1});
    @(negedge clk);
    in_valid = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
  endtask

  task automatic drain(input bit rand_ready);
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      n++;
    end
    check("drain", sb.size(), 0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("out_valid_seen", out_valid, 1'b1);
  endtask

  initial begin
    logic [15:0] x, y;
    repeat (2) @(negedge clk);
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_out", out, 16'h0000);
    reset = 1'b1;
    out_ready = 1'b1;

    // 1.0 x 1.0, then back to IDLE one edge after the transfer
    issue(16'h3F80, 16'h3F80, 16'h3F80);
    wait_valid();
    @(negedge clk);
    check("idle_in_ready", in_ready, 1'b1);
    check("idle_out_valid", out_valid, 1'b0);

    issue(16'h4000, 16'hC040, 16'hC0C0); drain(0);
    issue(16'h3FC0, 16'h3FC0, 16'h4010); drain(0);
    issue(16'h7F80, 16'h3F80, 16'hFFFF); drain(0);
    issue(16'h0000, 16'h4000, 16'h0000); drain(0);
    issue(16'h8000, 16'hC000, 16'h0000); drain(0);
    issue(16'h7F00, 16'h7F00, 16'hFFFF); drain(0);
    issue(16'h0080, 16'h0080, 16'h0000); drain(0);
    issue(16'h3FC1, 16'h3FC1, RNE ? 16'h4012 : 16'h4011); drain(0);
    issue(16'h0040, 16'h4000, 16'h0080); drain(0);
    issue(16'h0040, 16'hBF80, 16'h8040); drain(0);

    // Backpressure: output held, new requests ignored
    out_ready = 1'b0;
    issue(16'h3F80, 16'h4000, 16'h4000);
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_out", out, 16'h4000);
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_in_ready", in_ready, 1'b0);
      in_valid = (i % 2 == 0);
      a = 16'($urandom);
      b = 16'($urandom);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    issue(16'h4000, 16'h4000, 16'h4080);
    drain(0);

    // Random operands, random backpressure
    for (int i = 0; i < 300; i++) begin
      x = rnd_op();
      y = rnd_op();
      issue(x, y, model(x, y));
      drain(1);
    end

    // Reset during MULT aborts the operation
    issue(16'h3F80, 16'h4000, 16'h4000);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out", out, 16'h0000);
    sb.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_hold_valid", out_valid, 1'b0);
    end
    @(negedge clk);
    reset = 1'b1;
    issue(16'h3F80, 16'h4000, 16'h4000);
    drain(0);

    repeat (8) @(negedge clk);
    check("final_idle_valid", out_valid, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
